// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, issues req/ack fetches
//               to instruction memory, buffers a word across decode stalls,
//               yields to data-memory conflicts and flushes on taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        mem_conflict,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc_plus1
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic        r_outstanding;
    logic [15:0] r_hold_instr;
    logic [15:0] r_hold_pc;
    logic [15:0] r_redirect_pc;
    logic        r_valid;
    logic [15:0] r_instr;
    logic [15:0] r_if_pc;
    logic [15:0] r_if_pc_plus1;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_pc_nxt;
    logic        w_outstanding_nxt;
    logic [15:0] w_hold_instr_nxt;
    logic [15:0] w_hold_pc_nxt;
    logic [15:0] w_redirect_nxt;
    logic        w_req;
    logic        w_acked;
    logic        w_load;
    logic [15:0] w_load_instr;
    logic [15:0] w_load_pc;

    // Request generation: once issued, a request stays up until acked.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            S_FETCH: w_req = r_outstanding | ~mem_conflict;
            S_HOLD:  w_req = 1'b0;
            S_DROP:  w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    assign imem_req  = w_req & ~rst;
    assign imem_addr = r_pc;
    assign w_acked   = w_req & imem_ack;

    // Next-state, PC and buffer update; a branch overrides everything else.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_outstanding_nxt = r_outstanding;
        w_hold_instr_nxt  = r_hold_instr;
        w_hold_pc_nxt     = r_hold_pc;
        w_redirect_nxt    = r_redirect_pc;
        w_load            = 1'b0;
        w_load_instr      = r_hold_instr;
        w_load_pc         = r_hold_pc;
        if (branch_taken) begin
            if (w_req & ~imem_ack) begin
                // The in-flight request must finish at its address; remember
                // where to go once the stale word arrives.
                w_redirect_nxt    = branch_target;
                w_state_nxt       = S_DROP;
                w_outstanding_nxt = 1'b1;
            end else begin
                w_pc_nxt          = branch_target;
                w_state_nxt       = S_FETCH;
                w_outstanding_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_acked) begin
                        w_pc_nxt          = r_pc + 16'd1;
                        w_outstanding_nxt = 1'b0;
                        if (stall) begin
                            w_hold_instr_nxt = imem_data;
                            w_hold_pc_nxt    = r_pc;
                            w_state_nxt      = S_HOLD;
                        end else begin
                            w_load       = 1'b1;
                            w_load_instr = imem_data;
                            w_load_pc    = r_pc;
                        end
                    end else begin
                        w_outstanding_nxt = w_req;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        w_pc_nxt          = r_redirect_pc;
                        w_outstanding_nxt = 1'b0;
                        w_state_nxt       = S_FETCH;
                    end
                end
                default: begin
                    w_state_nxt       = S_FETCH;
                    w_outstanding_nxt = 1'b0;
                end
            endcase
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_outstanding <= 1'b0;
            r_hold_instr  <= NOP_INSTR;
            r_hold_pc     <= 16'h0000;
            r_redirect_pc <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_hold_instr  <= w_hold_instr_nxt;
            r_hold_pc     <= w_hold_pc_nxt;
            r_redirect_pc <= w_redirect_nxt;
        end
    end

    // IF/ID register: reset > flush > stall hold > load > bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_if_pc       <= 16'h0000;
            r_if_pc_plus1 <= 16'h0001;
        end else if (branch_taken) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (stall) begin
            r_valid <= r_valid;
        end else if (w_load) begin
            r_valid       <= 1'b1;
            r_instr       <= w_load_instr;
            r_if_pc       <= w_load_pc;
            r_if_pc_plus1 <= w_load_pc + 16'd1;
        end else begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end
    end

    assign if_id_valid    = r_valid;
    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_if_pc;
    assign if_id_pc_plus1 = r_if_pc_plus1;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios then
//               randomized stall/conflict/branch/ack traffic against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [15:0] C_RESET_PC = 16'h0000;
    localparam logic [15:0] C_NOP      = 16'h0800;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        mem_conflict;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(C_RESET_PC), .NOP_INSTR(C_NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .mem_conflict   (mem_conflict),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: next fetch address, an in-flight request that may be
    // stale (redirect pending), and a one-deep queue of words decode refused.
    logic [15:0] m_pc;
    logic        m_busy;
    logic        m_drop;
    logic [15:0] m_after;
    logic [31:0] m_buf[$];
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic [15:0] e_pc1;

    function automatic logic model_req(input logic conf);
        if (m_buf.size() != 0) return 1'b0;
        if (m_drop) return 1'b1;
        return m_busy | ~conf;
    endfunction

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic deliver(input logic [31:0] w);
        e_valid = 1'b1;
        e_pc    = w[31:16];
        e_instr = w[15:0];
        e_pc1   = w[31:16] + 16'd1;
    endtask

    task automatic bubble();
        e_valid = 1'b0;
        e_instr = C_NOP;
    endtask

    task automatic model_update(input logic r, s, c, b, input logic [15:0] t,
                                input logic ack, input logic [15:0] d);
        logic req;
        if (r) begin
            m_pc = C_RESET_PC; m_busy = 1'b0; m_drop = 1'b0; m_after = 16'h0;
            m_buf.delete();
            e_valid = 1'b0; e_instr = C_NOP; e_pc = 16'h0000; e_pc1 = 16'h0001;
            return;
        end
        req = model_req(c);
        if (b) begin
            bubble();
            if (req && !ack) begin
                m_drop = 1'b1; m_after = t; m_busy = 1'b1;
            end else begin
                m_pc = t; m_busy = 1'b0; m_drop = 1'b0; m_buf.delete();
            end
        end else if (m_drop) begin
            if (ack) begin
                m_drop = 1'b0; m_busy = 1'b0; m_pc = m_after;
            end
            if (!s) bubble();
        end else if (m_buf.size() != 0) begin
            if (!s) deliver(m_buf.pop_front());
        end else if (req && ack) begin
            if (s) m_buf.push_back({m_pc, d});
            else   deliver({m_pc, d});
            m_pc   = m_pc + 16'd1;
            m_busy = 1'b0;
        end else begin
            m_busy = req;
            if (!s) bubble();
        end
    endtask

    // One clock: drive inputs at negedge, check request, answer, check IF/ID.
    // am: 0 = no ack, 1 = ack whenever requested, 2 = random ack.
    task automatic step(input logic r, s, c, b, input logic [15:0] t, input int am);
        logic        er;
        logic [15:0] ea;
        logic        ack;
        logic [15:0] d;
        @(negedge clk);
        rst = r; stall = s; mem_conflict = c; branch_taken = b; branch_target = t;
        er = r ? 1'b0 : model_req(c);
        ea = m_pc;
        #1;
        check16("imem_req", {15'd0, imem_req}, {15'd0, er});
        if (er) check16("imem_addr", imem_addr, ea);
        case (am)
            0:       ack = 1'b0;
            1:       ack = er;
            default: ack = er & ($urandom_range(0, 9) < 6);
        endcase
        d = ea + 16'h0100;
        imem_ack  = ack;
        imem_data = ack ? d : 16'($urandom);
        @(posedge clk);
        model_update(r, s, c, b, t, ack, d);
        #1;
        check16("if_id_valid", {15'd0, if_id_valid}, {15'd0, e_valid});
        check16("if_id_instr", if_id_instr, e_instr);
        check16("if_id_pc", if_id_pc, e_pc);
        check16("if_id_pc_plus1", if_id_pc_plus1, e_pc1);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; mem_conflict = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0; imem_ack = 1'b0; imem_data = 16'h0;
        m_pc = C_RESET_PC; m_busy = 1'b0; m_drop = 1'b0; m_after = 16'h0;
        e_valid = 1'b0; e_instr = C_NOP; e_pc = 16'h0; e_pc1 = 16'h1;

        // Reset, then streaming with ack tied to req.
        step(1, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 0, 16'h0, 0);
        check16("reset_instr", if_id_instr, 16'h0800);
        check16("reset_pc_plus1", if_id_pc_plus1, 16'h0001);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 16'h0, 1);
        check16("stream_pc4", if_id_pc, 16'h0004);
        check16("stream_instr4", if_id_instr, 16'h0104);

        // Stall while pc=5 is acked, then release.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'h0, 1);
        check16("stall_hold_pc", if_id_pc, 16'h0004);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0, 1);

        // Data-memory conflict with nothing outstanding.
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 16'h0, 1);
        step(0, 0, 0, 0, 16'h0, 1);

        // Branch with same-cycle ack, then branch during a delayed ack.
        step(0, 0, 0, 1, 16'h0020, 1);
        step(0, 0, 0, 0, 16'h0, 1);
        check16("branch_land_pc", if_id_pc, 16'h0020);
        step(0, 0, 0, 1, 16'h0040, 0);
        step(0, 0, 0, 0, 16'h0, 0);
        step(0, 0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 0, 16'h0, 1);
        check16("drop_land_pc", if_id_pc, 16'h0040);

        // PC wrap at 16'hFFFF.
        step(0, 0, 0, 1, 16'hFFFF, 1);
        step(0, 0, 0, 0, 16'h0, 1);
        check16("wrap_pc_plus1", if_id_pc_plus1, 16'h0000);
        step(0, 0, 0, 0, 16'h0, 1);

        // Reset while a word is being held.
        step(0, 1, 0, 0, 16'h0, 1);
        step(0, 1, 0, 0, 16'h0, 1);
        step(1, 1, 0, 0, 16'h0, 1);
        step(0, 0, 0, 0, 16'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 8),
                 16'($urandom), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
